// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard / halt controller:
// FSM state encoding, drain length, statistic width and register address width.
package pipeline_ctrl_pkg;

  // Number of cycles the pipeline spends draining before it reports halted.
  localparam int DRAIN_CYCLES = 3;

  // Width of the saturating statistic counters.
  localparam int STAT_W = 16;

  // Width of a register address field in the instruction word.
  localparam int REG_AW = 3;

  // Number of in-flight writer stages checked for hazards (EX, MEM, WB).
  localparam int N_WR_STAGES = 3;

  // Drain counter width; three cycles fit in two bits.
  localparam int DRAIN_W = 2;

  // Value loaded into the drain counter on entry to DRAIN.
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  // Controller state encoding; the numeric values are visible on ctrl_state.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } ctrl_state_e;

  // Bundle of the pipeline control outputs driven by the output decoder.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_flush;
    logic halt_ack;
  } ctrl_out_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_cmp.sv
// One source-register comparator: flags a read-after-write conflict when any
// valid in-flight writer (EX, MEM or WB) targets the same register. Register 0
// is treated like any other register.
import pipeline_ctrl_pkg::*;

module hazard_cmp (
  input  logic [REG_AW-1:0]                  field_i,
  input  logic [N_WR_STAGES-1:0]             wr_en_i,
  input  logic [N_WR_STAGES-1:0][REG_AW-1:0] wr_rd_i,
  output logic                               match_o
);

  logic [N_WR_STAGES-1:0] stage_hit;

  // Per-stage equality check, qualified by that stage's regwrite.
  for (genvar gi = 0; gi < N_WR_STAGES; gi++) begin : g_stage
    assign stage_hit[gi] = wr_en_i[gi] && (wr_rd_i[gi] == field_i);
  end

  assign match_o = |stage_hit;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard and halt controller.
// Detects RAW hazards against EX/MEM/WB writers, stalls the front end,
// flushes on a WB-resolved redirect, and runs a drain/halt handshake.
// Control outputs are combinational from state and current inputs with
// priority redirect > hazard > halt. Stall cycles and flush events are
// counted in saturating statistics.
import pipeline_ctrl_pkg::*;

module pipeline_hazard_ctrl (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_regwrite,
  input  logic              mem_regwrite,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_redirect,
  input  logic              halt_req,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_flush,
  output logic              halt_ack,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events,
  output logic [1:0]        ctrl_state
);

  // ---------------------------------------------------------------------------
  // Hazard detection: one comparator per source field (0 = rs, 1 = rt).
  // ---------------------------------------------------------------------------
  logic [1:0][REG_AW-1:0]                  src_field;
  logic [1:0]                              src_match;
  logic [N_WR_STAGES-1:0]                  wr_en;
  logic [N_WR_STAGES-1:0][REG_AW-1:0]      wr_rd;
  logic                                    hazard;

  assign src_field[0] = id_rs;
  assign src_field[1] = id_rt;

  assign wr_en = {wb_regwrite, mem_regwrite, ex_regwrite};
  assign wr_rd = {wb_rd, mem_rd, ex_rd};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    hazard_cmp u_cmp (
      .field_i (src_field[gi]),
      .wr_en_i (wr_en),
      .wr_rd_i (wr_rd),
      .match_o (src_match[gi])
    );
  end

  // rt only matters when the instruction actually reads it.
  assign hazard = id_valid && (src_match[0] || (id_uses_rt && src_match[1]));

  // ---------------------------------------------------------------------------
  // FSM state and drain counter.
  // ---------------------------------------------------------------------------
  ctrl_state_e         state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic                redirect_act;

  // A redirect is honoured everywhere except once the pipeline is halted.
  assign redirect_act = wb_redirect && (state_q != ST_HALTED);

  // State register: reset wins over every state, including DRAIN and HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic with redirect > hazard > halt priority.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (redirect_act) begin
      // After a flush, either resume or restart the drain from the top.
      if (halt_req) begin
        state_d = ST_DRAIN;
        drain_d = DRAIN_LOAD;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_RUN, ST_STALL: begin
          if (hazard) begin
            state_d = ST_STALL;
          end else if (halt_req) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (!halt_req) begin
            // Halt withdrawn: resume fetching; PC was held during the drain.
            state_d = ST_RUN;
          end else if (drain_q <= DRAIN_W'(1)) begin
            // Counter reaches zero this cycle: pipeline is empty.
            state_d = ST_HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
        ST_HALTED: begin
          if (!halt_req) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          drain_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: purely combinational from state and current inputs.
  // ---------------------------------------------------------------------------
  ctrl_out_t ctrl;

  // Control outputs; reset forces the pipeline registers to NOPs and freezes PC.
  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_bubble = 1'b1;
      ctrl.exmem_flush = 1'b1;
    end else if (redirect_act) begin
      // Load the target and squash the three younger stages.
      ctrl.pc_we       = 1'b1;
      ctrl.ifid_we     = 1'b1;
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_bubble = 1'b1;
      ctrl.exmem_flush = 1'b1;
    end else begin
      case (state_q)
        ST_RUN, ST_STALL: begin
          if (hazard) begin
            // Hold PC and IF/ID, inject a bubble into EX.
            ctrl.idex_bubble = 1'b1;
          end else begin
            ctrl.pc_we   = 1'b1;
            ctrl.ifid_we = 1'b1;
          end
        end
        ST_DRAIN: begin
          // Stop fetching and feed NOPs while older instructions retire.
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_bubble = 1'b1;
        end
        ST_HALTED: begin
          ctrl.halt_ack = 1'b1;
        end
        default: begin
          ctrl = '0;
        end
      endcase
    end
  end

  assign pc_we       = ctrl.pc_we;
  assign ifid_we     = ctrl.ifid_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign exmem_flush = ctrl.exmem_flush;
  assign halt_ack    = ctrl.halt_ack;
  assign ctrl_state  = state_q;

  // ---------------------------------------------------------------------------
  // Saturating statistics.
  // ---------------------------------------------------------------------------
  logic [STAT_W-1:0] stall_q, stall_d;
  logic [STAT_W-1:0] flush_q, flush_d;
  logic              stall_evt;

  // A stall is a frozen PC while in RUN or STALL; drain cycles do not count.
  assign stall_evt = !ctrl.pc_we && ((state_q == ST_RUN) || (state_q == ST_STALL));

  // Next values of the statistic counters.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_evt) begin
      stall_d = sat_inc(stall_q);
    end
    if (redirect_act) begin
      flush_d = sat_inc(flush_q);
    end
  end

  // Statistic registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: id_valid  input  1  IF/ID holds a real instruction.
REQ-004 SHALL have ports: id_rs, id_rt  input  3 each  source register fields [15:13], [12:10] of the ID instruction.
REQ-005 SHALL have port: id_uses_rt  input  1  ID instruction reads rt.
REQ-006 SHALL have ports: ex_regwrite, mem_regwrite, wb_regwrite  input  1 each  in-flight writer valid, per stage.
REQ-007 SHALL have ports: ex_rd, mem_rd, wb_rd  input  3 each  destination register, per stage.
REQ-008 SHALL have port: wb_redirect  input  1  jump, jmem or taken branch resolved in WB; PC loads target this cycle.
REQ-009 SHALL have port: halt_req  input  1  level request to quiesce the pipeline.
REQ-010 SHALL have ports: pc_we, ifid_we  output  1 each  PC and IF/ID write enables.
REQ-011 SHALL have ports: ifid_flush, idex_bubble, exmem_flush  output  1 each  clear the stage register to a NOP with all control signals 0.
REQ-012 SHALL have port: halt_ack  output  1  pipeline empty and frozen.
REQ-013 SHALL have ports: stall_cycles, flush_events  output  16 each  saturating statistics.
REQ-014 SHALL have port: ctrl_state  output  2  current FSM state encoding.

Function
REQ-015 hazard SHALL be id_valid AND (match on rs OR (id_uses_rt AND match on rt)), where a match is any stage in EX/MEM/WB with regwrite=1 and rd equal to the field; register 0 is not exempt.
REQ-016 FSM states SHALL be RUN=0, STALL=1, DRAIN=2, HALTED=3.
REQ-017 Outputs SHALL be combinational from state and current inputs, with priority redirect > hazard > halt.
REQ-018 On redirect in any state except HALTED: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1, exmem_flush=1; next state RUN, or DRAIN with drain count reloaded to 3 if halt_req=1.
REQ-019 RUN with no redirect and no hazard: pc_we=1, ifid_we=1, all flushes 0.
REQ-020 RUN or STALL with hazard and no redirect: pc_we=0, ifid_we=0, idex_bubble=1; next state STALL.
REQ-021 STALL with hazard cleared: behave as RUN in that cycle; next state RUN, or DRAIN if halt_req=1.
REQ-022 RUN with halt_req=1, no hazard and no redirect: next state DRAIN, with a 2-bit drain counter loaded with 3.
REQ-023 In DRAIN: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1; the counter decrements each cycle; at 0 the next state is HALTED.
REQ-024 halt_req deasserted during DRAIN SHALL return the FSM to RUN next cycle; the PC is unchanged.
REQ-025 In HALTED: halt_ack=1, all enables 0, all flushes 0, redirect ignored; halt_req=0 gives RUN next cycle; halt_ack is 0 in every other state.
REQ-026 stall_cycles SHALL increment every cycle with pc_we=0 in RUN or STALL, saturating at 0xFFFF.
REQ-027 flush_events SHALL increment once per cycle in which REQ-018 applies, saturating at 0xFFFF.
REQ-028 Simultaneous redirect and hazard SHALL resolve as redirect; no stall is counted.

Reset
REQ-029 rst=1 at a clock edge SHALL force RUN, drain counter 0, stall_cycles=0, flush_events=0 and halt_ack=0, regardless of the current state, including mid-DRAIN or HALTED.
REQ-030 While rst=1, outputs SHALL be pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, exmem_flush=1.

Structure
REQ-031 A shared package pipeline_ctrl_pkg SHALL hold the state encodings, DRAIN_CYCLES=3, STAT_W=16 and REG_AW=3.
REQ-032 A sub-module hazard_cmp SHALL be instantiated once per source field (rs, rt), comparing one field against the three stage writers.

Verification
REQ-033 Redirect: ex_regwrite=1, ex_rd=3, id_rs=3, wb_redirect=1 -> exactly one cycle with all three flushes=1 and pc_we=1, flush_events=1, stall_cycles=0.
REQ-034 Stall then release: ex_rd=5 with regwrite, id_rs=5, the writer then walks through MEM and WB -> 3 stall cycles with pc_we=0 and idex_bubble=1, RUN resumes in cycle 4, stall_cycles=3.
REQ-035 Halt handshake: halt_req=1 from RUN -> DRAIN for 3 cycles, then halt_ack=1; halt_req=0 -> RUN next cycle with halt_ack=0.
REQ-036 Redirect during DRAIN: wb_redirect=1 in DRAIN cycle 2 with halt_req held -> flushes fire, the counter reloads to 3, and halt_ack arrives 4 cycles later.
REQ-037 Saturation and reset: hazard held for 70000 cycles -> stall_cycles=0xFFFF; rst=1 for one cycle while HALTED -> RUN, both counters 0.
